// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types, constants and helpers for the round-robin bus arbiter.
package bus_arb_pkg;
  typedef enum logic [1:0] {IDLE, POP, DECODE, DELIVER} state_e;
  localparam int DEST_W  = 8;
  localparam int MAX_PKT = 512;
  // Destination ID sits in the top DEST_W bits of a packet that is sz bits wide.
  function automatic logic [DEST_W-1:0] dest_of(input logic [MAX_PKT-1:0] pkt, input int sz);
    return DEST_W'(pkt >> (sz - DEST_W));
  endfunction
endpackage

// File: rtl/bus_arbiter_rr_arbiter.sv
// rr_arbiter: combinational priority search over req.
//   req       : request vector
//   ptr       : search start index (round-robin mode only)
//   grant_idx : winning index
//   grant_vld : any request present
module rr_arbiter #(
  parameter int N    = 5,
  parameter bit MODE = 1'b1,
  localparam int IW  = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);
  logic [IW-1:0] base;
  logic [IW-1:0] idx;
  assign base = MODE ? ptr : '0;
  // Scan from the farthest offset back to the nearest so the nearest request wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IW'((int'(base) + i) % N);
      if (req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end
endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: shared-bus arbiter moving one packet at a time from a source FIFO to its targets.
//   clk, reset       : clock, asynchronous active-low reset
//   pndng / D_pop    : per-port head-valid and head data of the source FIFOs
//   pop              : one-cycle pop strobe to the granted source
//   full             : per-destination backpressure
//   push / D_push    : per-destination write strobe and latched packet
//   busy             : transaction in progress
//   pkt_cnt/drop_cnt/tout_cnt : saturating delivered / dropped / timed-out counters
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int         DRVRS     = 5,
  parameter int         PCKG_SZ   = 16,
  parameter logic [7:0] BROADCAST = 8'hFF,
  parameter int         ARB_MODE  = 1,
  parameter int         TIMEOUT   = 16,
  parameter int         CNT_W     = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DRVRS-1:0]                pndng,
  input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
  output logic [DRVRS-1:0]                pop,
  input  logic [DRVRS-1:0]                full,
  output logic [DRVRS-1:0]                push,
  output logic [DRVRS-1:0][PCKG_SZ-1:0]   D_push,
  output logic                            busy,
  output logic [CNT_W-1:0]                pkt_cnt,
  output logic [CNT_W-1:0]                drop_cnt,
  output logic [CNT_W-1:0]                tout_cnt
);
  localparam int IW = $clog2(DRVRS);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [IW-1:0] g_q, g_d, ptr_q, ptr_d, nxt_ptr, gnt_idx;
  logic gnt_vld;
  logic [PCKG_SZ-1:0] pkt_q, pkt_d;
  logic [DRVRS-1:0] rem_q, rem_d, pop_q, pop_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d, tout_cnt_q, tout_cnt_d;
  logic [DEST_W-1:0] dest;
  rr_arbiter #(.N(DRVRS), .MODE(ARB_MODE != 0)) u_arb (
    .req(pndng),
    .ptr(ptr_q),
    .grant_idx(gnt_idx),
    .grant_vld(gnt_vld)
  );
  assign dest = dest_of(MAX_PKT'(pkt_q), PCKG_SZ);
  assign nxt_ptr = (g_q == IW'(DRVRS - 1)) ? '0 : g_q + 1'b1;
  assign push = (state_q == DELIVER) ? rem_q & ~full : '0;
  assign D_push = {DRVRS{pkt_q}};
  assign pop = pop_q;
  assign busy = state_q != IDLE;
  assign pkt_cnt = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign tout_cnt = tout_cnt_q;
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    ptr_d = ptr_q;
    pkt_d = pkt_q;
    rem_d = rem_q;
    tmr_d = tmr_q;
    pop_d = '0;
    pkt_cnt_d = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    tout_cnt_d = tout_cnt_q;
    case (state_q)
      IDLE: if (gnt_vld) begin
        g_d = gnt_idx;
        pop_d = DRVRS'(1) << gnt_idx;
        state_d = POP;
      end
      POP: begin
        pkt_d = D_pop[g_q];
        state_d = DECODE;
      end
      DECODE: begin
        tmr_d = '0;
        if (dest == BROADCAST) begin
          rem_d = ~(DRVRS'(1) << g_q);
          state_d = DELIVER;
        end else if (int'(dest) < DRVRS && dest != DEST_W'(g_q)) begin
          rem_d = DRVRS'(1) << dest;
          state_d = DELIVER;
        end else begin
          drop_cnt_d = drop_cnt_q + CNT_W'(drop_cnt_q != '1);
          ptr_d = nxt_ptr;
          state_d = IDLE;
        end
      end
      DELIVER: begin
        rem_d = rem_q & ~push;
        tmr_d = tmr_q + 1'b1;
        if (rem_d == '0) begin
          pkt_cnt_d = pkt_cnt_q + CNT_W'(pkt_cnt_q != '1);
          ptr_d = nxt_ptr;
          state_d = IDLE;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          // Last permitted DELIVER cycle ended with targets still blocked.
          tout_cnt_d = tout_cnt_q + CNT_W'(tout_cnt_q != '1);
          rem_d = '0;
          ptr_d = nxt_ptr;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      g_q <= '0;
      ptr_q <= '0;
      pkt_q <= '0;
      rem_q <= '0;
      tmr_q <= '0;
      pop_q <= '0;
      pkt_cnt_q <= '0;
      drop_cnt_q <= '0;
      tout_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      ptr_q <= ptr_d;
      pkt_q <= pkt_d;
      rem_q <= rem_d;
      tmr_q <= tmr_d;
      pop_q <= pop_d;
      pkt_cnt_q <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      tout_cnt_q <= tout_cnt_d;
    end
  end
endmodule
